// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Optional debug halt support is enabled with CONTROL_UNIT_DEBUG_EN.
package control_unit_pkg;

  // Controller states; HALTED exists only in the debug build
  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_ILLEGAL
`ifdef CONTROL_UNIT_DEBUG_EN
    ,
    S_HALTED
`endif
  } state_e;

  // RV32I opcode classes recognised by the decoder
  typedef enum logic [3:0] {
    OPC_OP,
    OPC_OP_IMM,
    OPC_LUI,
    OPC_AUIPC,
    OPC_JAL,
    OPC_JALR,
    OPC_BRANCH,
    OPC_LOAD,
    OPC_STORE,
    OPC_SYSTEM,
    OPC_MISC_MEM,
    OPC_INVALID
  } opc_class_e;

  // Major opcodes, IR[6:0]
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;

  // Memory address source
  localparam logic ADDR_ALU = 1'b0;
  localparam logic ADDR_PC  = 1'b1;

  // Register-file write-back source
  localparam logic [1:0] RD_ALU = 2'b00;
  localparam logic [1:0] RD_MEM = 2'b01;
  localparam logic [1:0] RD_CSR = 2'b10;
  localparam logic [1:0] RD_PC4 = 2'b11;

  // ALU operand 1 source
  localparam logic [1:0] INSEL1_RS = 2'b00;
  localparam logic [1:0] INSEL1_PC = 2'b01;
  localparam logic [1:0] INSEL1_ZR = 2'b10;

  // ALU operand 2 source
  localparam logic [1:0] INSEL2_RS = 2'b00;
  localparam logic [1:0] INSEL2_IM = 2'b01;
  localparam logic [1:0] INSEL2_IS = 2'b10;

  // Next-PC source
  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

  // Core control-signal bundle driven by the controller
  typedef struct packed {
    logic       load_op;
    logic       write_pc;
    logic       write_ir;
    logic       write_rd;
    logic       write_csr;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic [1:0] rd_sel;
    logic [1:0] alu_insel1;
    logic [1:0] alu_insel2;
    logic       pc_sel;
  } ctrl_t;

  // Immediate shifts (SLLI/SRLI/SRAI) take the shamt operand
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier: IR opcode/f3 -> instruction class,
// legality and the f3-dependent sub-cases the controller needs.
module control_decode
  import control_unit_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  f3,
  output opc_class_e  opc_class,
  output logic        legal,
  output logic        is_shift,
  output logic        is_csr
);

  // Map the major opcode to a class; anything unrecognised is invalid
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    opc_class = OPC_INVALID;
    case (opcode)
      OPCODE_OP:       opc_class = OPC_OP;
      OPCODE_OP_IMM:   opc_class = OPC_OP_IMM;
      OPCODE_LUI:      opc_class = OPC_LUI;
      OPCODE_AUIPC:    opc_class = OPC_AUIPC;
      OPCODE_JAL:      opc_class = OPC_JAL;
      OPCODE_JALR:     opc_class = OPC_JALR;
      OPCODE_BRANCH:   opc_class = OPC_BRANCH;
      OPCODE_LOAD:     opc_class = OPC_LOAD;
      OPCODE_STORE:    opc_class = OPC_STORE;
      OPCODE_SYSTEM:   opc_class = OPC_SYSTEM;
      OPCODE_MISC_MEM: opc_class = OPC_MISC_MEM;
      default:         opc_class = OPC_INVALID;
    endcase
  end

  assign legal    = (opc_class != OPC_INVALID);
  assign is_shift = (opc_class == OPC_OP_IMM) && is_shift_f3(f3);
  assign is_csr   = (opc_class == OPC_SYSTEM) && (f3 != 3'b000);

endmodule

// File: rtl/control_unit.sv
// Multicycle main controller of the RV32I core. One instruction in flight:
// RESET -> FETCH -> DECODE -> EXEC [-> MEM] -> FETCH, ILLEGAL is terminal.
// Outputs are Mealy on mem_complete/cmp_true. Define CONTROL_UNIT_DEBUG_EN
// to add halt_req/resume_req/halted and a HALTED state at instruction
// boundaries.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned RESET_WAIT = 1  // 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       mem_complete,
  input  logic       cmp_true,
  output logic       load_op,
  output logic       write_pc,
  output logic       write_ir,
  output logic       write_rd,
  output logic       write_csr,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic [1:0] rd_sel,
  output logic [1:0] alu_insel1,
  output logic [1:0] alu_insel2,
  output logic       pc_sel,
  output logic       illegal
`ifdef CONTROL_UNIT_DEBUG_EN
  ,
  input  logic       halt_req,
  input  logic       resume_req,
  output logic       halted
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  ctrl_t      ctrl;

  opc_class_e opc_class;
  logic       legal;
  logic       is_shift;
  logic       is_csr;

  control_decode u_decode (
    .opcode    (opcode),
    .f3        (f3),
    .opc_class (opc_class),
    .legal     (legal),
    .is_shift  (is_shift),
    .is_csr    (is_csr)
  );

  // Next state, RESET wait counter and sticky illegal flag
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RESET: begin
        // cnt_q counts RESET cycles seen with rst_n released
        if (cnt_q >= WAIT_LAST) state_d = S_FETCH;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_FETCH:   if (mem_complete) state_d = S_DECODE;
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_ILLEGAL;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (opc_class == OPC_LOAD || opc_class == OPC_STORE) state_d = S_MEM;
        else                                                 state_d = S_FETCH;
      end
      S_MEM:     if (mem_complete) state_d = S_FETCH;
      S_ILLEGAL: state_d = S_ILLEGAL;
`ifdef CONTROL_UNIT_DEBUG_EN
      S_HALTED:  if (resume_req && !halt_req) state_d = S_FETCH;
`endif
      default:   state_d = S_RESET;
    endcase
`ifdef CONTROL_UNIT_DEBUG_EN
    // Halt only at an instruction boundary, never inside a FETCH wait
    if (state_d == S_FETCH && state_q != S_FETCH && halt_req) state_d = S_HALTED;
`endif
  end

  // State, counter and illegal flag registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; rst_n is sampled only on the clock edge.
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Control-bundle decode from state, instruction class and handshakes
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.addr_sel = ADDR_PC;
        ctrl.write_ir = mem_complete;
      end
      S_EXEC: begin
        case (opc_class)
          OPC_OP: begin
            ctrl.alu_insel1 = INSEL1_RS;
            ctrl.alu_insel2 = INSEL2_RS;
            ctrl.write_rd   = 1'b1;
            ctrl.rd_sel     = RD_ALU;
            ctrl.write_pc   = 1'b1;
            ctrl.pc_sel     = PC_PLUS4;
          end
          OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
            ctrl.alu_insel1 = (opc_class == OPC_LUI)   ? INSEL1_ZR :
                              (opc_class == OPC_AUIPC) ? INSEL1_PC : INSEL1_RS;
            ctrl.alu_insel2 = is_shift ? INSEL2_IS : INSEL2_IM;
            ctrl.write_rd   = 1'b1;
            ctrl.rd_sel     = RD_ALU;
            ctrl.write_pc   = 1'b1;
            ctrl.pc_sel     = PC_PLUS4;
          end
          OPC_JAL, OPC_JALR: begin
            ctrl.alu_insel1 = (opc_class == OPC_JAL) ? INSEL1_PC : INSEL1_RS;
            ctrl.alu_insel2 = INSEL2_IM;
            ctrl.write_rd   = 1'b1;
            ctrl.rd_sel     = RD_PC4;
            ctrl.write_pc   = 1'b1;
            ctrl.pc_sel     = PC_ALU;
          end
          OPC_BRANCH: begin
            ctrl.alu_insel1 = INSEL1_PC;
            ctrl.alu_insel2 = INSEL2_IM;
            ctrl.write_pc   = 1'b1;
            ctrl.pc_sel     = cmp_true;
          end
          OPC_LOAD, OPC_STORE: begin
            // Address computation only; the access happens in MEM
            ctrl.alu_insel1 = INSEL1_RS;
            ctrl.alu_insel2 = INSEL2_IM;
          end
          OPC_SYSTEM: begin
            ctrl.write_pc  = 1'b1;
            ctrl.pc_sel    = PC_PLUS4;
            if (is_csr) begin
              ctrl.write_rd  = 1'b1;
              ctrl.rd_sel    = RD_CSR;
              ctrl.write_csr = 1'b1;
            end
          end
          OPC_MISC_MEM: begin
            ctrl.write_pc = 1'b1;
            ctrl.pc_sel   = PC_PLUS4;
          end
          default: ctrl = '0;
        endcase
      end
      S_MEM: begin
        // Request held every MEM cycle until the memory reports completion
        ctrl.alu_insel1 = INSEL1_RS;
        ctrl.alu_insel2 = INSEL2_IM;
        ctrl.addr_sel   = ADDR_ALU;
        if (opc_class == OPC_LOAD) begin
          ctrl.mem_read = 1'b1;
          ctrl.load_op  = 1'b1;
          if (mem_complete) begin
            ctrl.write_rd = 1'b1;
            ctrl.rd_sel   = RD_MEM;
          end
        end else begin
          ctrl.mem_write = 1'b1;
        end
        if (mem_complete) begin
          ctrl.write_pc = 1'b1;
          ctrl.pc_sel   = PC_PLUS4;
        end
      end
      default: ctrl = '0;
    endcase
  end

  assign load_op    = ctrl.load_op;
  assign write_pc   = ctrl.write_pc;
  assign write_ir   = ctrl.write_ir;
  assign write_rd   = ctrl.write_rd;
  assign write_csr  = ctrl.write_csr;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign addr_sel   = ctrl.addr_sel;
  assign rd_sel     = ctrl.rd_sel;
  assign alu_insel1 = ctrl.alu_insel1;
  assign alu_insel2 = ctrl.alu_insel2;
  assign pc_sel     = ctrl.pc_sel;
  assign illegal    = illegal_q;

`ifdef CONTROL_UNIT_DEBUG_EN
  assign halted = (state_q == S_HALTED);
`endif

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle main controller of the RV32I core.
- Consumes opcode/f3 from the instruction register and mem_complete from the memory interface.
- Drives every strobe/select in the core control-signal bundle (load_op, write_*, mem_*, addr_sel, rd_sel, alu_insel*).
- Sits between IR/decode and the datapath; one instruction in flight, no overlap.

Parameters:
- RESET_WAIT, 1, cycles spent in RESET state after rst_n deasserts before first FETCH (1..15).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  IR[6:0]
- f3  in  3  IR[14:12]
- mem_complete  in  1  memory access done this cycle
- cmp_true  in  1  branch comparator result for current f3
- load_op  out  1  load extension path active
- write_pc  out  1  PC write strobe
- write_ir  out  1  IR write strobe
- write_rd  out  1  register-file write strobe
- write_csr  out  1  CSR write strobe
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- addr_sel  out  1  ADDR_ALU=0 / ADDR_PC=1
- rd_sel  out  2  ALU=00, MEM=01, CSR=10, PC4=11 (new constant RD_PC4)
- alu_insel1  out  2  RS=00, PC=01, ZR=10
- alu_insel2  out  2  RS=00, IM=01, IS=10
- pc_sel  out  1  0 = PC+4, 1 = ALU result
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Clock and reset:
  - Single clock.
  - rst_n sampled on clk edge only. While low, state <= RESET and counter cleared.
  - All outputs 0 combinationally while rst_n low and in RESET (addr_sel, rd_sel, alu_insel*, pc_sel = 0).
- Output timing:
  - State register is the only sequential element besides the RESET counter and the illegal flag.
  - Outputs are a combinational function of state, opcode, f3, mem_complete and cmp_true (Mealy on mem_complete/cmp_true).
- States: RESET, FETCH, DECODE, EXEC, MEM, ILLEGAL.
- RESET: count RESET_WAIT cycles -> FETCH.
- FETCH:
  - mem_read=1, addr_sel=PC.
  - Hold until mem_complete; that same cycle write_ir=1 -> DECODE.
- DECODE: no strobes, 1 cycle -> EXEC. Unknown opcode -> ILLEGAL.
- EXEC, by opcode:
  - OP: alu RS,RS; write_rd, rd_sel=ALU; write_pc, pc_sel=0 -> FETCH.
  - OP_IMM: alu RS,IM; shifts (f3=001/101) use IS; otherwise as OP.
  - LUI: alu ZR,IM; otherwise as OP.
  - AUIPC: alu PC,IM; otherwise as OP.
  - JAL: alu PC,IM; write_rd, rd_sel=PC4; write_pc, pc_sel=1 -> FETCH.
  - JALR: alu RS,IM; otherwise as JAL.
  - BRANCH: alu PC,IM; write_pc=1, pc_sel=cmp_true; no rd write -> FETCH.
  - LOAD/STORE: alu RS,IM; no strobes -> MEM.
  - SYSTEM with f3 != 000: write_rd, rd_sel=CSR; write_csr=1; write_pc, pc_sel=0 -> FETCH.
  - SYSTEM with f3 == 000, and MISC_MEM: write_pc, pc_sel=0 only (NOP) -> FETCH.
- MEM:
  - ALU inputs held RS,IM; addr_sel=ALU.
  - Loads: mem_read=1 and load_op=1 every MEM cycle. Stores: mem_write=1.
  - Wait for mem_complete; that cycle write_pc, pc_sel=0; loads also write_rd with rd_sel=MEM -> FETCH.
  - mem_read/mem_write held continuously until mem_complete; never dropped early.
- ILLEGAL:
  - All strobes 0; illegal=1.
  - Remains until reset; no PC advance.
- Boundary conditions:
  - mem_complete already high on FETCH/MEM entry completes in that same cycle (zero wait).
  - mem_complete outside FETCH/MEM is ignored.
  - Reset mid-access drops mem_read/mem_write on the next edge.
  - write_pc asserted exactly once per retired instruction.

Optional Feature:
- CONTROL_UNIT_DEBUG_EN adds ports halt_req (in), resume_req (in), halted (out), and a HALTED state.
- Halt entry: on transition into FETCH (instruction boundary), if halt_req=1, enter HALTED instead.
- In HALTED: no strobes, halted=1.
- Exit: resume_req=1 and halt_req=0 -> FETCH.
- halt_req does not interrupt an in-progress MEM/FETCH access.
- Without the macro: ports and state absent; behaviour otherwise identical.

Decomposition:
- Package control_unit_pkg holds:
  - state enum
  - RV32I opcode-class enum
  - RD_PC4 constant, added beside the existing RD_* selects in the control-signal header
- Sub-module control_decode (combinational): opcode/f3 -> class plus legal flag; used in DECODE/EXEC.

Test Plan:
- Reset: rst_n=0 for 3 cycles, RESET_WAIT=1 -> all outputs 0; first mem_read=1, addr_sel=1 exactly 2 cycles after rst_n=1.
- ADDI, opcode 0010011 f3=000, mem_complete on 3rd FETCH cycle -> write_ir same cycle; EXEC shows alu 00/01, write_rd=1, rd_sel=00, write_pc=1, pc_sel=0.
- LW, opcode 0000011, mem_complete after 4 MEM cycles -> mem_read and load_op high 4 cycles, addr_sel=0; write_rd with rd_sel=01 only in the last cycle.
- BEQ, opcode 1100011: with cmp_true=1 -> write_pc=1, pc_sel=1; with cmp_true=0 -> pc_sel=0; write_rd=0 in both.
- Opcode 1111111 -> illegal=1, no strobes for 20 cycles, cleared by reset.
- Debug (macro on): halt_req raised during SW MEM -> store completes, then halted=1; resume_req pulse -> FETCH next cycle.
